scan_decoder: RTL and testbench

Parametrised, registered N-to-2^N decoder for driving select lines such as display digit enables, bank selects and keypad column strobes. It supports four modes: direct one-hot decode, thermometer decode, auto-scan and hold. In auto-scan mode an internal counter walks the one-hot output across all lines with a programmable dwell time. It replaces ad-hoc combinational decoders wherever a glitch-free registered output or self-timed scanning is required.

---
 rtl/scan_decoder_if.sv | 17 +
 rtl/scan_decoder.sv | 125 ++++++++++++
 tb/tb_scan_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/scan_decoder_if.sv
// Select/scan bus between a controller and scan_decoder.
// The master drives mode, select and timing. The slave returns the decoded lines.
interface scan_decoder_if #(
    parameter int N  = 3,
    parameter int DW = 8
);
    logic              en;
    logic [1:0]        mode;
    logic [N-1:0]      i;
    logic [DW-1:0]     dwell;
    logic [2**N-1:0]   y;
    logic [N-1:0]      idx;
    logic              wrap;

    modport master (output en, mode, i, dwell, input y, idx, wrap);
    modport slave  (input en, mode, i, dwell, output y, idx, wrap);
endinterface

// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with one-hot, thermometer, auto-scan and hold modes.
// All outputs come straight from flops, so the select lines never glitch.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   S_LOAD | last enabled cycle was not a scan cycle; next scan cycle loads i
//   S_RUN  | scanning; dwell counter runs and idx steps on terminal count
//
// The scan state moves only on enabled cycles. A gap with en low therefore
// resumes the scan where it stopped. Any non-scan mode, or reset, sends the
// state back to S_LOAD, so the next scan cycle is a fresh entry.
module scan_decoder #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    scan_decoder_if.slave bus
);
    localparam int OUTS = 2**N;

    localparam logic [1:0]      MODE_ONEHOT = 2'b00;
    localparam logic [1:0]      MODE_THERM  = 2'b01;
    localparam logic [1:0]      MODE_SCAN   = 2'b10;
    localparam logic [1:0]      MODE_HOLD   = 2'b11;

    localparam logic [OUTS-1:0] Y_LSB   = {{(OUTS-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]    IDX_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]    IDX_MAX = '1;
    localparam logic [DW-1:0]   CNT_ONE = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic {S_LOAD, S_RUN} scan_state_t;

    scan_state_t     state_q, state_d;
    logic [OUTS-1:0] y_q, y_d;
    logic [N-1:0]    idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic [DW-1:0]   cnt_q, cnt_d;

    function automatic logic [OUTS-1:0] one_hot(input logic [N-1:0] sel);
        return Y_LSB << sel;
    endfunction

    function automatic logic [OUTS-1:0] thermo(input logic [N-1:0] sel);
        logic [OUTS-1:0] t;
        t = '0;
        for (int b = 0; b < OUTS; b++) begin
            t[b] = (b <= int'(sel));
        end
        return t;
    endfunction

    // Register the state, outputs and dwell counter. Reset has priority over all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            y_q     <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, decode and scan stepping logic.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;

        if (!bus.en) begin
            y_d = '0;
        end else begin
            unique case (bus.mode)
                MODE_ONEHOT: begin
                    idx_d   = bus.i;
                    y_d     = one_hot(bus.i);
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
                MODE_THERM: begin
                    idx_d   = bus.i;
                    y_d     = thermo(bus.i);
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
                MODE_SCAN: begin
                    state_d = S_RUN;
                    if (state_q == S_LOAD) begin
                        idx_d = bus.i;
                        y_d   = one_hot(bus.i);
                        cnt_d = '0;
                    end else if (cnt_q >= bus.dwell) begin
                        // The comparison uses >= so that lowering dwell below the count steps on the next cycle.
                        cnt_d  = '0;
                        idx_d  = idx_q + IDX_ONE;
                        y_d    = one_hot(idx_q + IDX_ONE);
                        wrap_d = (idx_q == IDX_MAX);
                    end else begin
                        // Re-drive the current line so a scan resumed after en=0 lights up again at once.
                        cnt_d = cnt_q + CNT_ONE;
                        y_d   = one_hot(idx_q);
                    end
                end
                MODE_HOLD: begin
                    state_d = S_LOAD;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder (N=3, DW=8): directed scenarios followed by random cycles.
// A behavioural model of the mode rules runs alongside the DUT.
module tb_scan_decoder;
    logic clk;
    logic rst;

    scan_decoder_if #(.N(3), .DW(8)) bus ();

    scan_decoder #(.N(3), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state. The previous mode is kept as -1 when a fresh entry is pending.
    int m_y, m_idx, m_wrap, m_cnt, m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input int m, input int si, input int dw);
        if (r) begin
            m_y = 0; m_idx = 0; m_wrap = 0; m_cnt = 0; m_prev = -1;
        end else if (!e) begin
            m_y = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            case (m)
                0: begin m_idx = si; m_y = 1 << si; m_cnt = 0; end
                1: begin m_idx = si; m_y = (1 << (si + 1)) - 1; m_cnt = 0; end
                2: begin
                    if (m_prev != 2) begin
                        m_idx = si; m_y = 1 << si; m_cnt = 0;
                    end else if (m_cnt >= dw) begin
                        m_wrap = (m_idx == 7) ? 1 : 0;
                        m_idx  = (m_idx + 1) % 8;
                        m_y    = 1 << m_idx;
                        m_cnt  = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                        m_y   = 1 << m_idx;
                    end
                end
                default: ;
            endcase
            m_prev = m;
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, then compare 1 ns after the edge.
    task automatic cyc(input bit r, input bit e, input int m, input int si, input int dw);
        rst       = r;
        bus.en    = e;
        bus.mode  = 2'(m);
        bus.i     = 3'(si);
        bus.dwell = 8'(dw);
        @(posedge clk);
        model_edge(r, e, m, si, dw);
        #1;
        chk("model_y",    32'(bus.y),    32'(m_y));
        chk("model_idx",  32'(bus.idx),  32'(m_idx));
        chk("model_wrap", 32'(bus.wrap), 32'(m_wrap));
    endtask

    initial begin
        m_y = 0; m_idx = 0; m_wrap = 0; m_cnt = 0; m_prev = -1;
        rst = 1'b1; bus.en = 1'b1; bus.mode = 2'b00; bus.i = 3'd5; bus.dwell = 8'd0;
        #1;

        // Reset for two cycles with one-hot i=5 on the inputs.
        cyc(1, 1, 0, 5, 0);
        cyc(1, 1, 0, 5, 0);
        chk("reset_y", 32'(bus.y), 32'h0);
        chk("reset_idx", 32'(bus.idx), 32'h0);
        chk("reset_wrap", 32'(bus.wrap), 32'h0);
        cyc(0, 1, 0, 5, 0);
        chk("first_after_reset_y", 32'(bus.y), 32'h20);
        chk("first_after_reset_idx", 32'(bus.idx), 32'h5);

        // One-hot sweep, then disable.
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 0, k, 0);
            chk("onehot_y", 32'(bus.y), 32'(1 << k));
        end
        cyc(0, 0, 0, 5, 0);
        chk("disable_y", 32'(bus.y), 32'h0);
        chk("disable_idx_hold", 32'(bus.idx), 32'h7);

        // Thermometer.
        cyc(0, 1, 1, 0, 0); chk("therm_0", 32'(bus.y), 32'h01);
        cyc(0, 1, 1, 3, 0); chk("therm_3", 32'(bus.y), 32'h0F);
        cyc(0, 1, 1, 7, 0); chk("therm_7", 32'(bus.y), 32'hFF);

        // Scan from 6 with dwell=2. One full 8-step period is 24 clocks.
        for (int c = 0; c <= 24; c++) begin
            cyc(0, 1, 2, 6, 2);
            if (c < 3)       chk("scan_y_40", 32'(bus.y), 32'h40);
            else if (c < 6)  chk("scan_y_80", 32'(bus.y), 32'h80);
            if (c == 6) begin
                chk("scan_wrap_y", 32'(bus.y), 32'h01);
                chk("scan_wrap_pulse", 32'(bus.wrap), 32'h1);
            end else begin
                chk("scan_no_wrap", 32'(bus.wrap), 32'h0);
            end
            if (c == 24) chk("scan_period_24", 32'(bus.y), 32'h40);
        end

        // Interruption: dwell=0 scan from 0, pause at idx=3.
        cyc(0, 1, 3, 0, 0);
        for (int c = 0; c < 4; c++) cyc(0, 1, 2, 0, 0);
        chk("pause_at_idx3", 32'(bus.idx), 32'h3);
        for (int c = 0; c < 4; c++) begin
            cyc(0, 0, 2, 0, 0);
            chk("paused_y", 32'(bus.y), 32'h0);
            chk("paused_idx", 32'(bus.idx), 32'h3);
        end
        cyc(0, 1, 2, 0, 0);
        chk("resume_y", 32'(bus.y), 32'h10);
        cyc(0, 1, 3, 1, 0);
        cyc(0, 1, 2, 1, 0);
        chk("hold_reentry_y", 32'(bus.y), 32'h02);

        // Mid-scan reset.
        cyc(0, 1, 3, 0, 0);
        for (int c = 0; c < 5; c++) cyc(0, 1, 2, 0, 0);
        chk("midscan_idx4", 32'(bus.idx), 32'h4);
        cyc(1, 1, 2, 2, 0);
        chk("midscan_rst_y", 32'(bus.y), 32'h0);
        chk("midscan_rst_idx", 32'(bus.idx), 32'h0);
        cyc(0, 1, 2, 2, 0);
        chk("post_rst_load_y", 32'(bus.y), 32'h04);
        chk("post_rst_no_wrap", 32'(bus.wrap), 32'h0);

        // Random traffic biased toward scanning with short dwell.
        for (int c = 0; c < 600; c++) begin
            bit r, e;
            int m, dw;
            r  = ($urandom_range(0, 59) == 0);
            e  = ($urandom_range(0, 9) != 0);
            m  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 2;
            dw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            cyc(r, e, m, int'($urandom_range(0, 7)), dw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
